uart_rx_deserializer: RTL

- UART receive path: recovers 8-bit frames from the serial line using a CLK that runs PRESCALE times the bit rate.
- Frame format: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Receive-side counterpart of the TX serializer. Delivers a parallel byte with a one-cycle valid pulse to the system-side synchronizer.
- Flags parity and stop-bit errors.

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/uart_rx_sampler.sv | 58 +++++
 rtl/uart_rx_deserializer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared state encoding and constants for the UART receive path.
package uart_rx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PRESCALE_W_DEF = 6;

    localparam int PRESCALE_X8  = 8;
    localparam int PRESCALE_X16 = 16;
    localparam int PRESCALE_X32 = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and mid-bit sampling for the UART receiver.
// UART_RX_MAJORITY_VOTE_EN selects a 2-of-3 vote around mid-bit instead of one sample.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sample_done,
    output logic                  sampled_bit,
    output logic                  bit_end
);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESCALE_W-1:0] half;
    logic                  mid_q, mid_d;

    assign half        = prescale >> 1;
    assign sample_done = (edge_cnt_q == half + PRESCALE_W'(1));
    assign bit_end     = (edge_cnt_q == prescale - PRESCALE_W'(1));

    always_comb begin
        edge_cnt_d = bit_end ? '0 : edge_cnt_q + PRESCALE_W'(1);
        if (clr) edge_cnt_d = '0;
        mid_d = (edge_cnt_q == half) ? rx_in : mid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_q <= '0;
            mid_q      <= 1'b1;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            mid_q      <= mid_d;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic early_q, early_d;

    always_comb early_d = (edge_cnt_q == half - PRESCALE_W'(1)) ? rx_in : early_q;

    always_ff @(posedge clk) begin
        if (rst) early_q <= 1'b1;
        else     early_q <= early_d;
    end

    // Third vote is the live line at the decision edge, so latency is unchanged.
    assign sampled_bit = (early_q & mid_q) | (early_q & rx_in) | (mid_q & rx_in);
`else
    assign sampled_bit = mid_q;
`endif

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: start, 8 data bits LSB first, optional parity, stop.
// Build with UART_RX_MAJORITY_VOTE_EN for majority-voted bit decisions.
module uart_rx_deserializer
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);

    rx_state_e             state_q, state_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_mis_q, par_mis_d;
    logic                  valid_q, valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  sample_done, sampled_bit, bit_end, cnt_clr;

    assign cnt_clr = (state_d == IDLE);

    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .clk         (CLK),
        .rst         (RST),
        .rx_in       (RX_IN),
        .clr         (cnt_clr),
        .prescale    (prescale_q),
        .sample_done (sample_done),
        .sampled_bit (sampled_bit),
        .bit_end     (bit_end)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        p_data_d   = p_data_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_mis_d  = par_mis_q;
        valid_d    = 1'b0;
        par_err_d  = 1'b0;
        stp_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Frame configuration is frozen at the start edge.
                if (!RX_IN) begin
                    state_d    = START;
                    prescale_d = PRESCALE;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_mis_d  = 1'b0;
                end
            end
            START: begin
                if (sample_done && sampled_bit) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (sample_done) begin
                    shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
                if (bit_end && bit_cnt_q == BCW'(DATA_WIDTH))
                    state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (sample_done)
                    par_mis_d = ((^shift_q) ^ (par_typ_q == PAR_ODD)) != sampled_bit;
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                // Leave at the decision so a back-to-back start edge is not missed.
                if (sample_done) begin
                    state_d   = IDLE;
                    par_err_d = par_mis_q;
                    stp_err_d = !sampled_bit;
                    if (!par_mis_q && sampled_bit) begin
                        valid_d  = 1'b1;
                        p_data_d = shift_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            p_data_q   <= '0;
            prescale_q <= PRESCALE_W'(PRESCALE_X8);
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            par_mis_q  <= 1'b0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            p_data_q   <= p_data_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_mis_q  <= par_mis_d;
            valid_q    <= valid_d;
            par_err_q  <= par_err_d;
            stp_err_q  <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;

endmodule
